gpu_core_param: RTL and testbench
=================================

// Module: gpu_core_param
// PURPOSE
//  Parametrised successor of the per-core GPU execution unit. Loads a program and an R0 seed from the
//  task scheduler (TS), executes it sequentially through F/D/E/M/WB, and accesses shared memory (SM)
//  with a req/val handshake. Generalised in data width, register count, imem depth and core count.
//  Adds defined div-by-zero, mid-run abort and a HALT opcode.
// PARAMETERS
//  DATA_W      8   datapath / register width, 4..16
//  NUM_REGS    16  register file entries, 2..16 (4-bit IR fields; index >= NUM_REGS reads 0, write dropped)
//  IMEM_DEPTH  16  instruction words per program, power of 2, 2..16
//  NUM_CORES   16  cores sharing the TS mask bus, 1..16; CID_W = max(1,$clog2(NUM_CORES))
//  SM_ADDR_W   12  shared-memory address width
// PORTS
//  clk                 in   1          clock
//  reset               in   1          synchronous, active-high
//  val_mask_ac         in   1          instruction[NUM_CORES-1:0] is an activation mask
//  val_ins             in   1          instruction holds a program word
//  val_R0              in   1          instruction[DATA_W-1:0] holds an R0 seed
//  instruction         in   16         TS broadcast bus
//  core_id             in   CID_W      static core index
//  rtr                 out  1          ready to receive (LOAD state)
//  ready               out  1          idle / program finished
//  mem_req_ld          out  1          SM load request
//  mem_req_st          out  1          SM store request
//  addr_shared_memory  out  SM_ADDR_W  SM address
//  mem_dat_st          out  DATA_W     store data
//  mem_dat             in   DATA_W     load data
//  val_data            in   1          SM completion strobe
// BEHAVIOUR
//  Reset: state IDLE, ready=1, rtr=0, mem_req_*=0, addr=0, mem_dat_st=0, PC=0, all RF=0, counters=0.
//  States IDLE, NA, LOAD, F, D, E, M, MW, WB. rtr=1 only in LOAD; ready=1 only in IDLE/NA.
//  val_mask_ac, mask bit core_id set: -> LOAD from ANY state (abort: mem_req_* drop next cycle,
//   pending val_data ignored, PC/word/seed counters=0, RF kept). Bit clear: IDLE/LOAD -> NA; ignored
//   when running. NA leaves only on a set-bit mask.
//  LOAD: val_ins writes imem[wcnt++]; k-th val_R0 (k from 0) writes R0 when k==core_id; seeds past
//   NUM_CORES-1 ignored. When wcnt reaches IMEM_DEPTH -> F next cycle. val_ins+val_R0 same cycle: both.
//  F: IR=imem[PC]. D: A=RF[IR[11:8]], B=RF[IR[7:4]], S=RF[IR[3:0]]. E: ALU. M: ld/st -> MW else WB.
//  Latency: non-memory instr 5 cycles (F..WB); ld/st 5 + SM wait cycles (MW >= 1 cycle).
//  Opcodes (IR[15:12]); results mod 2^DATA_W, dest IR[3:0]:
//   0 nop; 1 add; 2 sub; 3 mul (low DATA_W); 4 div (B==0 -> all ones); 5 cmpge (A>=B ? 1 : 0);
//   6 A>>B, 7 A<<B (B>=DATA_W -> 0); 8 and; 9 or; 10 xor;
//   11 ld addr={A,B} zero-ext/trunc to SM_ADDR_W; 12 IR[3]==0: core_id -> R[IR[3:0]],
//      else imm IR[11:4] (trunc/zero-ext) -> R[IR[3:0]]; 13 st addr={A,B}, data=S;
//   14 bnz: A!=0 -> PC=IR[7:4] mod IMEM_DEPTH; 15 halt.
//  SM handshake: in M assert one mem_req_*, addr, data; hold stable until val_data=1 in MW; req=0 and
//   -> WB the following cycle. ld captures mem_dat on that edge. val_data outside MW ignored.
//  WB: write RF; PC+1, or branch target if taken. End (ready=1, PC=0, -> IDLE) on halt, or on
//   retiring PC==IMEM_DEPTH-1 without a taken branch. Else -> F.
//  reset has priority over everything incl. val_mask_ac.
// CONFIGURATION
//  GPU_CORE_DIV_EN defined: opcode 4 = divide as above.
//  Not defined: no divider synthesised; opcode 4 = nop (no RF write, 5 cycles).
// TESTING
//  reset; mask 0x0001 core_id=0 -> LOAD, rtr=1; 16 val_ins -> F next cycle, rtr=0, ready=0.
//  seeds R0: val_R0 x3 (5,6,7), core_id=2 -> R0=7; core_id=3 same stream -> R0 unchanged (0).
//  DATA_W=8: R1=200,R2=100 add->R3=44; div R1/R0 with R0=0 -> 0xFF (DIV_EN), R3 unchanged without.
//  ld R1=0x3,R2=0x45 -> addr 0x345, req held 4 cycles until val_data, mem_dat=0xA5 -> dest=0xA5.
//  mask with bit set while in MW -> LOAD, mem_req_ld=0 next cycle, late val_data ignored.
//  bnz R1!=0 target 2 loop 3x then halt -> ready=1, PC=0, state IDLE; mask bit clear in IDLE -> NA.

Source files
------------

// File: rtl/gpu_core_param_if.sv
// gpu_core_param_if: task-scheduler broadcast bus and shared-memory handshake of one GPU core.
// master = scheduler / shared-memory side, slave = core side.
interface gpu_core_param_if #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned SM_ADDR_W = 12
);
   logic                 val_mask_ac;
   logic                 val_ins;
   logic                 val_R0;
   logic [15:0]          instruction;
   logic                 rtr;
   logic                 ready;
   logic                 mem_req_ld;
   logic                 mem_req_st;
   logic [SM_ADDR_W-1:0] addr_shared_memory;
   logic [DATA_W-1:0]    mem_dat_st;
   logic [DATA_W-1:0]    mem_dat;
   logic                 val_data;

   modport master (
      output val_mask_ac, val_ins, val_R0, instruction, mem_dat, val_data,
      input  rtr, ready, mem_req_ld, mem_req_st, addr_shared_memory, mem_dat_st
   );

   modport slave (
      input  val_mask_ac, val_ins, val_R0, instruction, mem_dat, val_data,
      output rtr, ready, mem_req_ld, mem_req_st, addr_shared_memory, mem_dat_st
   );
endinterface

// File: rtl/gpu_core_param.sv
// gpu_core_param: parametrised sequential GPU core (LOAD, then F/D/E/M/(MW)/WB per instruction).
// Optional feature macro: GPU_CORE_DIV_EN enables the opcode-4 divider; without it opcode 4 is a nop.
module gpu_core_param #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned NUM_REGS   = 16,
   parameter int unsigned IMEM_DEPTH = 16,
   parameter int unsigned NUM_CORES  = 16,
   parameter int unsigned SM_ADDR_W  = 12,
   localparam int unsigned CID_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CID_W-1:0] core_id,
   gpu_core_param_if.slave  bus
);

   localparam int unsigned PC_W   = $clog2(IMEM_DEPTH);
   localparam int unsigned RA_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned SEED_W = CID_W + 1;

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_MUL  = 4'd3;
   localparam logic [3:0] OP_DIV  = 4'd4;
   localparam logic [3:0] OP_CGE  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_XOR  = 4'd10;
   localparam logic [3:0] OP_LD   = 4'd11;
   localparam logic [3:0] OP_CID  = 4'd12;
   localparam logic [3:0] OP_ST   = 4'd13;
   localparam logic [3:0] OP_BNZ  = 4'd14;
   localparam logic [3:0] OP_HALT = 4'd15;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_NA = 4'd1, S_LOAD = 4'd2, S_F = 4'd3, S_D = 4'd4,
      S_E = 4'd5, S_M = 4'd6, S_MW = 4'd7, S_WB = 4'd8
   } state_e;

   state_e               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d, wcnt_q, wcnt_d;
   logic [SEED_W-1:0]    seed_q, seed_d;
   logic [15:0]          ir_q, ir_d;
   logic [DATA_W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d, res_q, res_d;
   logic                 wr_q, wr_d;
   logic                 rtr_q, rtr_d, ready_q, ready_d;
   logic                 req_ld_q, req_ld_d, req_st_q, req_st_d;
   logic [SM_ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]    dat_st_q, dat_st_d;

   logic [15:0]          imem_q [IMEM_DEPTH];
   logic [DATA_W-1:0]    rf_q   [NUM_REGS];

   logic                 imem_we_c;
   logic                 rf_we_c;
   logic [3:0]           rf_wa_c;
   logic [DATA_W-1:0]    rf_wd_c;
   logic                 mask_hit_c;
   logic                 taken_c;
   logic [3:0]           op_c;
   logic [DATA_W-1:0]    rd_a_c, rd_b_c, rd_s_c;

   assign op_c = ir_q[15:12];

   // Register-file read ports; indices past NUM_REGS read as zero.
   assign rd_a_c = (32'(ir_q[11:8]) < NUM_REGS) ? rf_q[RA_W'(ir_q[11:8])] : '0;
   assign rd_b_c = (32'(ir_q[7:4])  < NUM_REGS) ? rf_q[RA_W'(ir_q[7:4])]  : '0;
   assign rd_s_c = (32'(ir_q[3:0])  < NUM_REGS) ? rf_q[RA_W'(ir_q[3:0])]  : '0;

   assign mask_hit_c = bus.val_mask_ac && (32'(core_id) < NUM_CORES) && bus.instruction[4'(core_id)];
   assign taken_c    = (op_c == OP_BNZ) && (a_q != '0);

   // Next-state, datapath and register/imem write control.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      wcnt_d    = wcnt_q;
      seed_d    = seed_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      s_d       = s_q;
      res_d     = res_q;
      wr_d      = wr_q;
      req_ld_d  = req_ld_q;
      req_st_d  = req_st_q;
      addr_d    = addr_q;
      dat_st_d  = dat_st_q;
      imem_we_c = 1'b0;
      rf_we_c   = 1'b0;
      rf_wa_c   = 4'd0;
      rf_wd_c   = '0;

      if (mask_hit_c) begin
         // Activation (or abort) from any state: restart loading, keep the register file.
         state_d  = S_LOAD;
         pc_d     = '0;
         wcnt_d   = '0;
         seed_d   = '0;
         req_ld_d = 1'b0;
         req_st_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (bus.val_mask_ac) state_d = S_NA;
            S_NA:   state_d = S_NA;
            S_LOAD: begin
               if (bus.val_mask_ac) begin
                  state_d = S_NA;
               end else begin
                  if (bus.val_ins) begin
                     imem_we_c = 1'b1;
                     wcnt_d    = wcnt_q + 1'b1;
                     if (wcnt_q == PC_W'(IMEM_DEPTH - 1)) state_d = S_F;
                  end
                  if (bus.val_R0 && (32'(seed_q) < NUM_CORES)) begin
                     seed_d = seed_q + 1'b1;
                     if (seed_q == SEED_W'(core_id)) begin
                        rf_we_c = 1'b1;
                        rf_wa_c = 4'd0;
                        rf_wd_c = bus.instruction[DATA_W-1:0];
                     end
                  end
               end
            end
            S_F: begin
               ir_d    = imem_q[pc_q];
               state_d = S_D;
            end
            S_D: begin
               a_d     = rd_a_c;
               b_d     = rd_b_c;
               s_d     = rd_s_c;
               state_d = S_E;
            end
            S_E: begin
               wr_d    = 1'b1;
               res_d   = '0;
               state_d = S_M;
               case (op_c)
                  OP_ADD: res_d = a_q + b_q;
                  OP_SUB: res_d = a_q - b_q;
                  OP_MUL: res_d = a_q * b_q;
                  OP_DIV: begin
`ifdef GPU_CORE_DIV_EN
                     res_d = (b_q == '0) ? '1 : a_q / b_q;
`else
                     wr_d  = 1'b0;
`endif
                  end
                  OP_CGE: res_d = (a_q >= b_q) ? DATA_W'(1) : '0;
                  OP_SHR: res_d = (32'(b_q) >= DATA_W) ? '0 : (a_q >> b_q);
                  OP_SHL: res_d = (32'(b_q) >= DATA_W) ? '0 : (a_q << b_q);
                  OP_AND: res_d = a_q & b_q;
                  OP_OR:  res_d = a_q | b_q;
                  OP_XOR: res_d = a_q ^ b_q;
                  OP_LD:  res_d = '0;
                  OP_CID: res_d = ir_q[3] ? DATA_W'(ir_q[11:4]) : DATA_W'(core_id);
                  default: wr_d = 1'b0;
               endcase
            end
            S_M: begin
               state_d = S_WB;
               if (op_c == OP_LD) begin
                  req_ld_d = 1'b1;
                  addr_d   = SM_ADDR_W'({a_q, b_q});
                  state_d  = S_MW;
               end else if (op_c == OP_ST) begin
                  req_st_d = 1'b1;
                  addr_d   = SM_ADDR_W'({a_q, b_q});
                  dat_st_d = s_q;
                  state_d  = S_MW;
               end
            end
            S_MW: begin
               if (bus.val_data) begin
                  if (req_ld_q) res_d = bus.mem_dat;
                  req_ld_d = 1'b0;
                  req_st_d = 1'b0;
                  state_d  = S_WB;
               end
            end
            S_WB: begin
               if (wr_q) begin
                  rf_we_c = 1'b1;
                  rf_wa_c = ir_q[3:0];
                  rf_wd_c = res_q;
               end
               if ((op_c == OP_HALT) || ((pc_q == PC_W'(IMEM_DEPTH - 1)) && !taken_c)) begin
                  pc_d    = '0;
                  state_d = S_IDLE;
               end else begin
                  pc_d    = taken_c ? PC_W'(ir_q[7:4]) : pc_q + 1'b1;
                  state_d = S_F;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      rtr_d   = (state_d == S_LOAD);
      ready_d = (state_d == S_IDLE) || (state_d == S_NA);
   end

   // State, pipeline and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         wcnt_q   <= '0;
         seed_q   <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= '0;
         res_q    <= '0;
         wr_q     <= 1'b0;
         rtr_q    <= 1'b0;
         ready_q  <= 1'b1;
         req_ld_q <= 1'b0;
         req_st_q <= 1'b0;
         addr_q   <= '0;
         dat_st_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         wcnt_q   <= wcnt_d;
         seed_q   <= seed_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         s_q      <= s_d;
         res_q    <= res_d;
         wr_q     <= wr_d;
         rtr_q    <= rtr_d;
         ready_q  <= ready_d;
         req_ld_q <= req_ld_d;
         req_st_q <= req_st_d;
         addr_q   <= addr_d;
         dat_st_q <= dat_st_d;
      end
   end

   // Instruction memory write port (contents undefined until loaded).
   always_ff @(posedge clk) begin
      if (imem_we_c) imem_q[wcnt_q] <= bus.instruction;
   end

   // Register file write port; indices past NUM_REGS are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
      end else if (rf_we_c && (32'(rf_wa_c) < NUM_REGS)) begin
         rf_q[RA_W'(rf_wa_c)] <= rf_wd_c;
      end
   end

   assign bus.rtr                = rtr_q;
   assign bus.ready              = ready_q;
   assign bus.mem_req_ld         = req_ld_q;
   assign bus.mem_req_st         = req_st_q;
   assign bus.addr_shared_memory = addr_q;
   assign bus.mem_dat_st         = dat_st_q;

endmodule

// File: tb/tb_gpu_core_param.sv
// tb_gpu_core_param: directed bench for gpu_core_param (DATA_W=8, 16 regs, 16-word imem, 16 cores).
module tb_gpu_core_param;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] core_id = 4'd0;
   int         n_vec = 0;
   int         n_err = 0;
   int         n;

   logic [15:0] prog_a [16];
   logic [15:0] prog_b [16];
   logic [15:0] prog_c [16];

   gpu_core_param_if #(.DATA_W(8), .SM_ADDR_W(12)) bus ();

   gpu_core_param #(
      .DATA_W(8), .NUM_REGS(16), .IMEM_DEPTH(16), .NUM_CORES(16), .SM_ADDR_W(12)
   ) dut (
      .clk(clk),
      .reset(reset),
      .core_id(core_id),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_mask(input logic [15:0] mask);
      bus.val_mask_ac = 1'b1;
      bus.instruction = mask;
      tick();
      bus.val_mask_ac = 1'b0;
      bus.instruction = '0;
   endtask

   task automatic send_seed(input logic [15:0] v);
      bus.val_R0      = 1'b1;
      bus.instruction = v;
      tick();
      bus.val_R0      = 1'b0;
      bus.instruction = '0;
   endtask

   task automatic load_prog(input logic [15:0] p [16], input bit seed0);
      for (int i = 0; i < 16; i++) begin
         bus.val_ins     = 1'b1;
         bus.val_R0      = seed0 && (i == 0);
         bus.instruction = p[i];
         tick();
      end
      bus.val_ins     = 1'b0;
      bus.val_R0      = 1'b0;
      bus.instruction = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      bus.val_mask_ac = 1'b0;
      bus.val_ins     = 1'b0;
      bus.val_R0      = 1'b0;
      bus.instruction = '0;
      bus.mem_dat     = '0;
      bus.val_data    = 1'b0;

      // R9=200 R10=100 R11=R9+R10; R12=3 R13=1 R14=0; loop: R14+=R9, R12-=R13, bnz R12->6; halt
      prog_a = '{16'hCC89, 16'hC64A, 16'h19AB, 16'hC03C, 16'hC01D, 16'hC00E, 16'h1E9E, 16'h2CDC,
                 16'hEC60, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      // ALU / ld / st mix ending on a nop at the last imem word
      prog_b = '{16'hC001, 16'hC039, 16'hC45A, 16'hB9A5, 16'h5A96, 16'h3AA7, 16'h6A98, 16'h7A9B,
                 16'h49FC, 16'hA9AD, 16'hD9A0, 16'h4A9E, 16'h8A5F, 16'h99A2, 16'h6AAA, 16'h0000};
      // nop (doubles as 4th seed), R9=3, R10=0x45, ld R5 (aborted), nops
      prog_c = '{16'h0042, 16'hC039, 16'hC45A, 16'hB9A5, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

      // Reset state
      repeat (3) tick();
      check("rst_ready", 32'(bus.ready), 1);
      check("rst_rtr", 32'(bus.rtr), 0);
      check("rst_req_ld", 32'(bus.mem_req_ld), 0);
      check("rst_req_st", 32'(bus.mem_req_st), 0);
      check("rst_addr", 32'(bus.addr_shared_memory), 0);
      check("rst_dat_st", 32'(bus.mem_dat_st), 0);
      check("rst_pc", 32'(dut.pc_q), 0);
      check("rst_state", 32'(dut.state_q), 0);
      reset = 1'b0;
      tick();

      // Core 0: activate, load program A, run add + branch loop + halt
      core_id = 4'd0;
      pulse_mask(16'h0001);
      check("a_load_rtr", 32'(bus.rtr), 1);
      check("a_load_ready", 32'(bus.ready), 0);
      load_prog(prog_a, 1'b0);
      check("a_f_rtr", 32'(bus.rtr), 0);
      check("a_f_ready", 32'(bus.ready), 0);
      check("a_f_state", 32'(dut.state_q), 3);
      n = 0;
      while (!bus.ready && n < 1000) begin tick(); n++; end
      check("a_cycles", 32'(n), 80);
      check("a_add_r11", 32'(dut.rf_q[11]), 32'h2C);
      check("a_loop_r14", 32'(dut.rf_q[14]), 32'h58);
      check("a_loop_r12", 32'(dut.rf_q[12]), 0);
      check("a_end_pc", 32'(dut.pc_q), 0);
      check("a_end_state", 32'(dut.state_q), 0);
      pulse_mask(16'h0002);
      check("a_na_state", 32'(dut.state_q), 1);
      check("a_na_ready", 32'(bus.ready), 1);

      // Core 2: seeds 5,6,7 -> R0=7; program B with ld (4-cycle wait) and st
      core_id = 4'd2;
      do_reset();
      pulse_mask(16'h0004);
      send_seed(16'h0005);
      send_seed(16'h0006);
      send_seed(16'h0007);
      check("b_seed_r0", 32'(dut.rf_q[0]), 7);
      load_prog(prog_b, 1'b0);
      n = 0;
      while (!bus.mem_req_ld && n < 200) begin tick(); n++; end
      check("b_ld_req", 32'(bus.mem_req_ld), 1);
      check("b_ld_lat", 32'(n), 19);
      check("b_ld_addr", 32'(bus.addr_shared_memory), 32'h345);
      check("b_ld_st_idle", 32'(bus.mem_req_st), 0);
      for (int j = 0; j < 3; j++) begin
         tick();
         check("b_ld_hold", 32'(bus.mem_req_ld), 1);
         check("b_ld_addr_hold", 32'(bus.addr_shared_memory), 32'h345);
      end
      bus.val_data = 1'b1;
      bus.mem_dat  = 8'hA5;
      tick();
      bus.val_data = 1'b0;
      bus.mem_dat  = '0;
      check("b_ld_drop", 32'(bus.mem_req_ld), 0);
      n = 0;
      while (!bus.mem_req_st && n < 200) begin tick(); n++; end
      check("b_st_req", 32'(bus.mem_req_st), 1);
      check("b_st_addr", 32'(bus.addr_shared_memory), 32'h345);
      check("b_st_data", 32'(bus.mem_dat_st), 7);
      bus.val_data = 1'b1;
      tick();
      bus.val_data = 1'b0;
      check("b_st_drop", 32'(bus.mem_req_st), 0);
      n = 0;
      while (!bus.ready && n < 1000) begin tick(); n++; end
      check("b_done", 32'(bus.ready), 1);
      check("b_cid_r1", 32'(dut.rf_q[1]), 2);
      check("b_ld_r5", 32'(dut.rf_q[5]), 32'hA5);
      check("b_cge_r6", 32'(dut.rf_q[6]), 1);
      check("b_mul_r7", 32'(dut.rf_q[7]), 32'h99);
      check("b_shr_r8", 32'(dut.rf_q[8]), 32'h08);
      check("b_shl_r11", 32'(dut.rf_q[11]), 32'h28);
      check("b_xor_r13", 32'(dut.rf_q[13]), 32'h46);
      check("b_and_r15", 32'(dut.rf_q[15]), 32'h05);
      check("b_or_r2", 32'(dut.rf_q[2]), 32'h47);
      check("b_shr_big_r10", 32'(dut.rf_q[10]), 0);
      check("b_r0_kept", 32'(dut.rf_q[0]), 7);
`ifdef GPU_CORE_DIV_EN
      check("b_div0_r12", 32'(dut.rf_q[12]), 32'hFF);
      check("b_div_r14", 32'(dut.rf_q[14]), 32'h17);
`else
      check("b_div0_r12", 32'(dut.rf_q[12]), 0);
      check("b_div_r14", 32'(dut.rf_q[14]), 0);
`endif
      check("b_end_pc", 32'(dut.pc_q), 0);

      // Core 3: same seed stream ignored, 4th seed rides with word 0; abort in MW
      core_id = 4'd3;
      do_reset();
      pulse_mask(16'h0008);
      send_seed(16'h0005);
      send_seed(16'h0006);
      send_seed(16'h0007);
      check("c_seed_r0", 32'(dut.rf_q[0]), 0);
      load_prog(prog_c, 1'b1);
      check("c_seed_ins_r0", 32'(dut.rf_q[0]), 32'h42);
      n = 0;
      while (!bus.mem_req_ld && n < 200) begin tick(); n++; end
      check("c_ld_req", 32'(bus.mem_req_ld), 1);
      check("c_ld_lat", 32'(n), 19);
      tick();
      pulse_mask(16'h0008);
      check("c_abort_req", 32'(bus.mem_req_ld), 0);
      check("c_abort_rtr", 32'(bus.rtr), 1);
      bus.val_data = 1'b1;
      bus.mem_dat  = 8'h77;
      tick();
      bus.val_data = 1'b0;
      bus.mem_dat  = '0;
      check("c_late_rtr", 32'(bus.rtr), 1);
      check("c_late_r5", 32'(dut.rf_q[5]), 0);
      check("c_abort_pc", 32'(dut.pc_q), 0);
      load_prog(prog_a, 1'b0);
      check("c_reload_rtr", 32'(bus.rtr), 0);
      n = 0;
      while (!bus.ready && n < 1000) begin tick(); n++; end
      check("c_cycles", 32'(n), 80);
      check("c_add_r11", 32'(dut.rf_q[11]), 32'h2C);
      check("c_rf_kept_r0", 32'(dut.rf_q[0]), 32'h42);
      pulse_mask(16'h0001);
      check("c_na_state", 32'(dut.state_q), 1);
      pulse_mask(16'h0008);
      check("c_na_load_rtr", 32'(bus.rtr), 1);
      check("c_na_load_ready", 32'(bus.ready), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
